// File: rtl/tone_mixer_pkg.sv
// Shared types and width helpers for the tone mixer.
// Envelope state is only used when TONE_MIXER_ENV_EN is defined.
package tone_mixer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ATTACK  = 2'd1,
        SUSTAIN = 2'd2,
        RELEASE = 2'd3
    } env_state_t;

    // $clog2 that never returns 0, so single-entry selects still get a bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Mix accumulator width: wide enough that NCH full-scale channels cannot overflow.
    function automatic int unsigned mix_width(input int unsigned out_w, input int unsigned nch);
        return out_w + $clog2(nch) + 1;
    endfunction

endpackage

// File: rtl/tone_mixer_channel.sv
// One tone channel: square-wave divider plus amplitude envelope.
// TONE_MIXER_ENV_EN selects the ADSR-style envelope; otherwise amp is a gated constant.
module tone_channel
    import tone_mixer_pkg::*;
#(
    parameter int unsigned DIV_W   = 16,
    parameter int unsigned AMP_W   = 6,
    parameter int unsigned DEF_DIV = 50
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_tick,
    input  logic             i_switch,
    input  logic             i_wr,
    input  logic [DIV_W-1:0] i_wr_div,
    output logic             o_square,
    output logic [AMP_W-1:0] o_amp,
    output logic             o_active
);

    localparam logic [AMP_W-1:0] AMP_MAX = '1;

    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_cnt;
    logic             r_square;
    logic [AMP_W-1:0] r_amp;
    logic             r_active;

    // Half-period divider; a write restarts the waveform from a low phase.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_div    <= DIV_W'(DEF_DIV);
            r_cnt    <= '0;
            r_square <= 1'b0;
        end else if (i_wr) begin
            r_div    <= i_wr_div;
            r_cnt    <= '0;
            r_square <= 1'b0;
        end else if (r_div == '0) begin
            r_cnt    <= '0;
            r_square <= 1'b0;
        end else if (r_cnt == r_div - DIV_W'(1)) begin
            r_cnt    <= '0;
            r_square <= ~r_square;
        end else begin
            r_cnt    <= r_cnt + DIV_W'(1);
        end
    end

`ifdef TONE_MIXER_ENV_EN
    env_state_t       r_state;
    env_state_t       w_state_nxt;
    logic [AMP_W-1:0] w_amp_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_amp    <= '0;
            r_active <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_amp    <= w_amp_nxt;
            r_active <= (w_state_nxt != IDLE);
        end
    end

    // Key changes win over ticks; re-press in RELEASE keeps the current amplitude.
    always_comb begin
        w_state_nxt = r_state;
        w_amp_nxt   = r_amp;
        case (r_state)
            IDLE: begin
                if (i_switch) w_state_nxt = ATTACK;
            end
            ATTACK: begin
                if (!i_switch)               w_state_nxt = RELEASE;
                else if (r_amp == AMP_MAX)   w_state_nxt = SUSTAIN;
                else if (i_tick)             w_amp_nxt   = r_amp + AMP_W'(1);
            end
            SUSTAIN: begin
                if (!i_switch) w_state_nxt = RELEASE;
            end
            RELEASE: begin
                if (i_switch)                w_state_nxt = ATTACK;
                else if (r_amp == '0)        w_state_nxt = IDLE;
                else if (i_tick)             w_amp_nxt   = r_amp - AMP_W'(1);
            end
            default: w_state_nxt = IDLE;
        endcase
    end
`else
    logic w_unused_tick;
    assign w_unused_tick = i_tick;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_amp    <= '0;
            r_active <= 1'b0;
        end else begin
            r_amp    <= i_switch ? AMP_MAX : '0;
            r_active <= i_switch;
        end
    end
`endif

    assign o_square = r_square;
    assign o_amp    = r_amp;
    assign o_active = r_active;

endmodule

// File: rtl/tone_mixer.sv
// Multi-channel tone generator: NCH tone_channel instances, envelope prescaler and saturating mix.
// Define TONE_MIXER_ENV_EN to enable the per-channel envelope and its prescaler.
module tone_mixer
    import tone_mixer_pkg::*;
#(
    parameter int unsigned NCH     = 4,
    parameter int unsigned OUT_W   = 8,
    parameter int unsigned DIV_W   = 16,
    parameter int unsigned AMP_W   = 6,
    parameter int unsigned ENV_DIV = 256,
    parameter int unsigned DEF_DIV = 50
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NCH-1:0]              switches,
    input  logic                        wr_en,
    input  logic [clog2_min1(NCH)-1:0]  wr_ch,
    input  logic [DIV_W-1:0]            wr_div,
    output logic [OUT_W-1:0]            combined,
    output logic [NCH-1:0]              active
);

    localparam int unsigned SUM_W = mix_width(OUT_W, NCH);
    localparam int unsigned PRE_W = clog2_min1(ENV_DIV);
    localparam logic [OUT_W-1:0] OUT_MAX = '1;

    logic                 w_tick;
    logic [NCH-1:0]       w_square;
    logic [NCH-1:0]       w_active;
    logic [NCH-1:0]       w_wr;
    logic [AMP_W-1:0]     w_amp [NCH];
    logic [SUM_W-1:0]     w_sum;
    logic [OUT_W-1:0]     r_combined;

`ifdef TONE_MIXER_ENV_EN
    logic [PRE_W-1:0] r_presc;

    assign w_tick = (r_presc == PRE_W'(ENV_DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst_n)      r_presc <= '0;
        else if (w_tick) r_presc <= '0;
        else             r_presc <= r_presc + PRE_W'(1);
    end
`else
    logic [PRE_W-1:0] w_unused_presc;
    assign w_unused_presc = PRE_W'(ENV_DIV - 1);
    assign w_tick         = 1'b0;
`endif

    // Out-of-range channel numbers match no instance, so such writes are dropped.
    for (genvar g = 0; g < NCH; g++) begin : g_ch
        assign w_wr[g] = wr_en && (32'(wr_ch) == 32'(g));

        tone_channel #(
            .DIV_W   (DIV_W),
            .AMP_W   (AMP_W),
            .DEF_DIV (DEF_DIV)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_tick   (w_tick),
            .i_switch (switches[g]),
            .i_wr     (w_wr[g]),
            .i_wr_div (wr_div),
            .o_square (w_square[g]),
            .o_amp    (w_amp[g]),
            .o_active (w_active[g])
        );
    end

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < NCH; i++) begin
            if (w_square[i]) w_sum = w_sum + SUM_W'(w_amp[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)                      r_combined <= '0;
        else if (w_sum > SUM_W'(OUT_MAX)) r_combined <= OUT_MAX;
        else                             r_combined <= OUT_W'(w_sum);
    end

    assign combined = r_combined;
    assign active   = w_active;

endmodule

// File: tb/tb_tone_mixer.sv
// Scoreboard bench for tone_mixer (NCH=3 so an out-of-range channel is encodable, AMP_W=7).
// Covers both builds: envelope checks apply when TONE_MIXER_ENV_EN is defined.
module tb_tone_mixer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  switches;
    logic        wr_en;
    logic [1:0]  wr_ch;
    logic [15:0] wr_div;
    logic [7:0]  combined;
    logic [2:0]  active;

    always #5 clk = ~clk;

    tone_mixer #(
        .NCH     (3),
        .OUT_W   (8),
        .DIV_W   (16),
        .AMP_W   (7),
        .ENV_DIV (4),
        .DEF_DIV (50)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .switches (switches),
        .wr_en    (wr_en),
        .wr_ch    (wr_ch),
        .wr_div   (wr_div),
        .combined (combined),
        .active   (active)
    );

    typedef struct {
        int         cyc;
        logic [7:0] comb;
        logic [2:0] act;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic exp_at(input int c, input int comb, input logic [2:0] act, input string name);
        exp_t e;
        e.cyc  = c;
        e.comb = 8'(comb);
        e.act  = act;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic goto(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Monitor: pops every expectation due at this cycle and compares both outputs.
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            checks++;
            if (e.cyc != cyc) begin
                errors++;
                $display("FAIL %s: sample for cycle %0d missed, now cycle %0d", e.name, e.cyc, cyc);
            end else begin
                if (combined !== e.comb) begin
                    errors++;
                    $display("FAIL %s combined @%0d: got %0d expected %0d", e.name, cyc, combined, e.comb);
                end
                checks++;
                if (active !== e.act) begin
                    errors++;
                    $display("FAIL %s active @%0d: got %b expected %b", e.name, cyc, active, e.act);
                end
            end
        end
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: stimulus did not complete, cycle %0d", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        int r;
        int r2;
        rst_n    = 1'b0;
        switches = 3'b000;
        wr_en    = 1'b0;
        wr_ch    = 2'd0;
        wr_div   = 16'd0;
        r        = 4;

        exp_at(r, 0, 3'b000, "reset");
        goto(r);
        rst_n    = 1'b1;
        switches = 3'b001;
`ifdef TONE_MIXER_ENV_EN
        // Envelope: amp = k at r+4k while attacking, squares high in [r+50+100m, r+99+100m].
        exp_at(r + 1,   0,   3'b001, "attack_start");
        exp_at(r + 51,  12,  3'b001, "attack_ramp");
        exp_at(r + 100, 24,  3'b001, "attack_ramp_end");
        exp_at(r + 101, 0,   3'b001, "square_low");
        exp_at(r + 551, 127, 3'b001, "sustain_peak");

        goto(r + 600);
        switches = 3'b000;
        exp_at(r + 601, 0,   3'b001, "release_start");
        exp_at(r + 651, 115, 3'b001, "release_ramp");
        exp_at(r + 700, 103, 3'b001, "release_ramp_end");
        exp_at(r + 989, 30,  3'b001, "release_at_30");

        goto(r + 990);
        switches = 3'b001;
        exp_at(r + 992, 30, 3'b001, "repress_hold");
        exp_at(r + 993, 31, 3'b001, "repress_resume");

        goto(r + 995);
        rst_n = 1'b0;
        exp_at(r + 996, 0, 3'b000, "reset_midnote");

        goto(r + 997);
        rst_n = 1'b1;
        r2    = r + 997;
        exp_at(r2 + 1, 0, 3'b001, "attack_after_reset");

        goto(r2 + 10);
        switches = 3'b000;
        exp_at(r2 + 16, 0, 3'b001, "release_tail");
        exp_at(r2 + 17, 0, 3'b000, "release_idle");
        goto(r2 + 20);
`else
        // Gated amp: 127 one cycle after key on; squares high in [r+50+100m, r+99+100m].
        exp_at(r + 1,   0,   3'b001, "key_on");
        exp_at(r + 50,  0,   3'b001, "square_first_low");
        exp_at(r + 51,  127, 3'b001, "square_first_high");
        exp_at(r + 100, 127, 3'b001, "square_last_high");
        exp_at(r + 101, 0,   3'b001, "square_low_again");

        goto(r + 120);
        switches = 3'b011;
        exp_at(r + 121, 0,   3'b011, "two_keys_low");
        exp_at(r + 150, 0,   3'b011, "two_keys_edge");
        exp_at(r + 151, 254, 3'b011, "two_keys_sum");

        goto(r + 160);
        switches = 3'b111;
        exp_at(r + 161, 254, 3'b111, "mix_latency");
        exp_at(r + 162, 255, 3'b111, "saturate");

        goto(r + 175);
        switches = 3'b011;
        exp_at(r + 176, 255, 3'b011, "saturate_hold");
        exp_at(r + 177, 254, 3'b011, "key_off_ch2");

        goto(r + 180);
        wr_en  = 1'b1;
        wr_ch  = 2'd1;
        wr_div = 16'd0;
        exp_at(r + 181, 254, 3'b011, "write_latency");
        exp_at(r + 182, 127, 3'b011, "ch1_div0_silent");
        goto(r + 181);
        wr_en = 1'b0;

        goto(r + 185);
        wr_en  = 1'b1;
        wr_ch  = 2'd3;
        wr_div = 16'd0;
        exp_at(r + 187, 127, 3'b011, "bad_channel_ignored");
        exp_at(r + 199, 127, 3'b011, "bad_channel_still");
        goto(r + 186);
        wr_en = 1'b0;

        goto(r + 200);
        wr_en  = 1'b1;
        wr_ch  = 2'd0;
        wr_div = 16'd3;
        exp_at(r + 204, 0,   3'b011, "div3_low");
        exp_at(r + 205, 127, 3'b011, "div3_high");
        exp_at(r + 207, 127, 3'b011, "div3_high_end");
        exp_at(r + 208, 0,   3'b011, "div3_low2");
        exp_at(r + 211, 127, 3'b011, "div3_high2");
        goto(r + 201);
        wr_en = 1'b0;

        goto(r + 211);
        switches = 3'b000;
        exp_at(r + 212, 127, 3'b000, "key_off_latency");
        exp_at(r + 213, 0,   3'b000, "key_off_silent");

        goto(r + 220);
        switches = 3'b001;
        exp_at(r + 221, 0,   3'b001, "rekey");
        exp_at(r + 223, 127, 3'b001, "rekey_sound");

        goto(r + 230);
        rst_n = 1'b0;
        exp_at(r + 231, 0, 3'b000, "reset_midnote");

        goto(r + 232);
        rst_n = 1'b1;
        r2    = r + 232;
        exp_at(r2 + 1,  0,   3'b001, "post_reset_key");
        exp_at(r2 + 50, 0,   3'b001, "div_restored_low");
        exp_at(r2 + 51, 127, 3'b001, "div_restored_high");
        goto(r2 + 55);
`endif

        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL %s: expectation for cycle %0d never sampled", e.name, e.cyc);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
